// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID-side inputs, EX/MEM producer state and registered EX outputs of the ID/EX stage
interface id_ex_stage_if #(
    parameter int XLEN = 32,
    parameter int REG_AW = 5
);
    logic              stall;
    logic              flush;
    logic              id_valid;
    logic [XLEN-1:0]   id_pc;
    logic [XLEN-1:0]   id_rs1_data;
    logic [XLEN-1:0]   id_rs2_data;
    logic [XLEN-1:0]   id_imm;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic              id_a_pc;
    logic              id_b_imm;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_mem_write;
    logic [3:0]        id_alu_op;
    logic [1:0]        id_wb_sel;
    logic              mem_valid;
    logic              mem_reg_write;
    logic [REG_AW-1:0] mem_rd;
    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_rs1_data;
    logic [XLEN-1:0]   ex_rs2_data;
    logic [XLEN-1:0]   ex_imm;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic [3:0]        ex_alu_op;
    logic [1:0]        ex_wb_sel;
    logic [1:0]        ex_a_sel;
    logic [1:0]        ex_b_sel;
    logic [1:0]        ex_st_sel;
    logic              hazard_stall;

    modport master (
        output stall, flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_a_pc, id_b_imm,
               id_reg_write, id_mem_read, id_mem_write, id_alu_op, id_wb_sel,
               mem_valid, mem_reg_write, mem_rd,
        input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_op, ex_wb_sel,
               ex_a_sel, ex_b_sel, ex_st_sel, hazard_stall
    );

    modport slave (
        input  stall, flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_a_pc, id_b_imm,
               id_reg_write, id_mem_read, id_mem_write, id_alu_op, id_wb_sel,
               mem_valid, mem_reg_write, mem_rd,
        output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_op, ex_wb_sel,
               ex_a_sel, ex_b_sel, ex_st_sel, hazard_stall
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with early operand-mux select codes and load-use bubble insertion
module id_ex_stage (
    input logic          clk,
    input logic          rst_n,
    id_ex_stage_if.slave bus
);
    logic       exm1, exm2, mwb1, mwb2, bubble;
    logic [1:0] f2, a_nx, b_nx, st_nx;

    always_comb begin
        exm1 = |bus.id_rs1 && bus.ex_valid && bus.ex_reg_write && bus.ex_rd == bus.id_rs1;
        exm2 = |bus.id_rs2 && bus.ex_valid && bus.ex_reg_write && bus.ex_rd == bus.id_rs2;
        mwb1 = |bus.id_rs1 && bus.mem_valid && bus.mem_reg_write && bus.mem_rd == bus.id_rs1;
        mwb2 = |bus.id_rs2 && bus.mem_valid && bus.mem_reg_write && bus.mem_rd == bus.id_rs2;
        f2 = exm2 ? 2'b01 : mwb2 ? 2'b10 : 2'b00;
        a_nx = bus.id_a_pc ? 2'b11 : !bus.id_use_rs1 ? 2'b00 : exm1 ? 2'b01 : mwb1 ? 2'b10 : 2'b00;
        b_nx = bus.id_b_imm ? 2'b11 : bus.id_use_rs2 ? f2 : 2'b00;
        st_nx = bus.id_use_rs2 && bus.id_mem_write ? f2 : 2'b00;
        bus.hazard_stall = bus.id_valid && bus.ex_valid && bus.ex_mem_read && |bus.ex_rd &&
                           ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) ||
                            (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd));
        // flush overrides a freeze; a load-use bubble only enters when the pipe is moving
        bubble = bus.flush || (!bus.stall && bus.hazard_stall);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ex_valid     <= 1'b0;
            bus.ex_pc        <= '0;
            bus.ex_rs1_data  <= '0;
            bus.ex_rs2_data  <= '0;
            bus.ex_imm       <= '0;
            bus.ex_rd        <= '0;
            bus.ex_reg_write <= 1'b0;
            bus.ex_mem_read  <= 1'b0;
            bus.ex_mem_write <= 1'b0;
            bus.ex_alu_op    <= '0;
            bus.ex_wb_sel    <= '0;
            bus.ex_a_sel     <= '0;
            bus.ex_b_sel     <= '0;
            bus.ex_st_sel    <= '0;
        end else if (bubble) begin
            bus.ex_valid     <= 1'b0;
            bus.ex_reg_write <= 1'b0;
            bus.ex_mem_read  <= 1'b0;
            bus.ex_mem_write <= 1'b0;
            bus.ex_a_sel     <= '0;
            bus.ex_b_sel     <= '0;
            bus.ex_st_sel    <= '0;
        end else if (!bus.stall) begin
            bus.ex_valid     <= bus.id_valid;
            bus.ex_pc        <= bus.id_pc;
            bus.ex_rs1_data  <= bus.id_rs1_data;
            bus.ex_rs2_data  <= bus.id_rs2_data;
            bus.ex_imm       <= bus.id_imm;
            bus.ex_rd        <= bus.id_rd;
            bus.ex_reg_write <= bus.id_reg_write && bus.id_valid;
            bus.ex_mem_read  <= bus.id_mem_read && bus.id_valid;
            bus.ex_mem_write <= bus.id_mem_write && bus.id_valid;
            bus.ex_alu_op    <= bus.id_alu_op;
            bus.ex_wb_sel    <= bus.id_wb_sel;
            bus.ex_a_sel     <= a_nx;
            bus.ex_b_sel     <= b_nx;
            bus.ex_st_sel    <= st_nx;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed test-plan steps plus random traffic checked against a
// per-instruction reference model of what EX should hold after each edge
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_ex_stage_if bus ();
    id_ex_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int errors = 0;
    int checks = 0;

    logic        m_valid, m_rw, m_mr, m_mw;
    logic [31:0] m_pc, m_d1, m_d2, m_imm;
    logic [4:0]  m_rd;
    logic [3:0]  m_alu;
    logic [1:0]  m_wb, m_a, m_b, m_st;
    logic [31:0] snap [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        {m_valid, m_rw, m_mr, m_mw} = '0;
        {m_pc, m_d1, m_d2, m_imm} = '0;
        m_rd = '0; m_alu = '0; m_wb = '0; m_a = '0; m_b = '0; m_st = '0;
    endtask

    function automatic logic model_haz();
        return bus.id_valid && m_valid && m_mr && m_rd != 0 &&
               ((bus.id_use_rs1 && bus.id_rs1 == m_rd) || (bus.id_use_rs2 && bus.id_rs2 == m_rd));
    endfunction

    // which producer supplies register r: newest in-flight writer wins, x0 never forwarded
    function automatic logic [1:0] src(input logic [4:0] r, input logic u);
        if (!u || r == 0) return 2'b00;
        if (m_valid && m_rw && m_rd == r) return 2'b01;
        if (bus.mem_valid && bus.mem_reg_write && bus.mem_rd == r) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_edge();
        logic haz;
        haz = model_haz();
        if (bus.flush || (!bus.stall && haz)) begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_a = 0; m_b = 0; m_st = 0;
        end else if (!bus.stall) begin
            m_a = bus.id_a_pc ? 2'b11 : src(bus.id_rs1, bus.id_use_rs1);
            m_b = bus.id_b_imm ? 2'b11 : src(bus.id_rs2, bus.id_use_rs2);
            m_st = src(bus.id_rs2, bus.id_use_rs2 && bus.id_mem_write);
            m_valid = bus.id_valid;
            m_pc = bus.id_pc; m_d1 = bus.id_rs1_data; m_d2 = bus.id_rs2_data; m_imm = bus.id_imm;
            m_rd = bus.id_rd; m_alu = bus.id_alu_op; m_wb = bus.id_wb_sel;
            m_rw = bus.id_reg_write && bus.id_valid;
            m_mr = bus.id_mem_read && bus.id_valid;
            m_mw = bus.id_mem_write && bus.id_valid;
        end
    endtask

    task automatic check_all();
        chk("ex_valid", 32'(bus.ex_valid), 32'(m_valid));
        chk("ex_reg_write", 32'(bus.ex_reg_write), 32'(m_rw));
        chk("ex_mem_read", 32'(bus.ex_mem_read), 32'(m_mr));
        chk("ex_mem_write", 32'(bus.ex_mem_write), 32'(m_mw));
        chk("ex_a_sel", 32'(bus.ex_a_sel), 32'(m_a));
        chk("ex_b_sel", 32'(bus.ex_b_sel), 32'(m_b));
        chk("ex_st_sel", 32'(bus.ex_st_sel), 32'(m_st));
        if (m_valid) begin
            chk("ex_pc", bus.ex_pc, m_pc);
            chk("ex_rs1_data", bus.ex_rs1_data, m_d1);
            chk("ex_rs2_data", bus.ex_rs2_data, m_d2);
            chk("ex_imm", bus.ex_imm, m_imm);
            chk("ex_rd", 32'(bus.ex_rd), 32'(m_rd));
            chk("ex_alu_op", 32'(bus.ex_alu_op), 32'(m_alu));
            chk("ex_wb_sel", 32'(bus.ex_wb_sel), 32'(m_wb));
        end
    endtask

    task automatic cycle();
        #1;
        chk("hazard_stall", 32'(bus.hazard_stall), 32'(model_haz()));
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic clear_in();
        bus.stall = 0; bus.flush = 0; bus.id_valid = 0;
        bus.id_pc = '0; bus.id_rs1_data = '0; bus.id_rs2_data = '0; bus.id_imm = '0;
        bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rd = '0;
        bus.id_use_rs1 = 0; bus.id_use_rs2 = 0; bus.id_a_pc = 0; bus.id_b_imm = 0;
        bus.id_reg_write = 0; bus.id_mem_read = 0; bus.id_mem_write = 0;
        bus.id_alu_op = '0; bus.id_wb_sel = '0;
        bus.mem_valid = 0; bus.mem_reg_write = 0; bus.mem_rd = '0;
    endtask

    task automatic instr(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic apc, input logic bimm,
                         input logic rw, input logic mr, input logic mw);
        bus.stall = 0; bus.flush = 0; bus.id_valid = 1;
        bus.id_pc = $urandom; bus.id_rs1_data = $urandom; bus.id_rs2_data = $urandom;
        bus.id_imm = $urandom; bus.id_alu_op = 4'($urandom); bus.id_wb_sel = 2'($urandom);
        bus.id_rd = rd; bus.id_rs1 = rs1; bus.id_rs2 = rs2;
        bus.id_use_rs1 = u1; bus.id_use_rs2 = u2; bus.id_a_pc = apc; bus.id_b_imm = bimm;
        bus.id_reg_write = rw; bus.id_mem_read = mr; bus.id_mem_write = mw;
    endtask

    task automatic rand_in();
        bus.stall = ($urandom_range(0, 7) == 0);
        bus.flush = ($urandom_range(0, 7) == 0);
        bus.id_valid = ($urandom_range(0, 3) != 0);
        bus.id_pc = $urandom; bus.id_rs1_data = $urandom; bus.id_rs2_data = $urandom;
        bus.id_imm = $urandom; bus.id_alu_op = 4'($urandom); bus.id_wb_sel = 2'($urandom);
        bus.id_rs1 = 5'($urandom_range(0, 3)); bus.id_rs2 = 5'($urandom_range(0, 3));
        bus.id_rd = 5'($urandom_range(0, 3));
        bus.id_use_rs1 = 1'($urandom); bus.id_use_rs2 = 1'($urandom);
        bus.id_a_pc = ($urandom_range(0, 3) == 0); bus.id_b_imm = ($urandom_range(0, 3) == 0);
        bus.id_reg_write = 1'($urandom); bus.id_mem_read = 1'($urandom);
        bus.id_mem_write = 1'($urandom);
        bus.mem_valid = 1'($urandom); bus.mem_reg_write = 1'($urandom);
        bus.mem_rd = 5'($urandom_range(0, 3));
    endtask

    initial begin
        clear_in();
        model_reset();
        #12;
        check_all();
        chk("reset_hazard", 32'(bus.hazard_stall), 32'd0);
        rst_n = 1;
        @(posedge clk);
        #1;

        // back-to-back ALU dependency: add x5 then sub x6,x5,x7
        instr(5, 1, 2, 1, 1, 0, 0, 1, 0, 0); cycle();
        instr(6, 5, 7, 1, 1, 0, 0, 1, 0, 0); cycle();
        chk("dep_a_sel", 32'(bus.ex_a_sel), 32'd1);
        chk("dep_b_sel", 32'(bus.ex_b_sel), 32'd0);
        chk("dep_valid", 32'(bus.ex_valid), 32'd1);

        // producer priority: EX and MEM both write x5, then EX not writing
        instr(5, 1, 2, 1, 1, 0, 0, 1, 0, 0); cycle();
        bus.mem_valid = 1; bus.mem_reg_write = 1; bus.mem_rd = 5;
        instr(9, 0, 5, 0, 1, 0, 0, 1, 0, 0); cycle();
        chk("prio_exm_b_sel", 32'(bus.ex_b_sel), 32'd1);
        instr(5, 1, 2, 1, 1, 0, 0, 0, 0, 0); cycle();
        instr(9, 0, 5, 0, 1, 0, 0, 1, 0, 0); cycle();
        chk("prio_mwb_b_sel", 32'(bus.ex_b_sel), 32'd2);
        bus.mem_valid = 0;

        // load-use: lw x5 then add x8,x5,x1
        instr(5, 2, 0, 1, 0, 0, 1, 1, 1, 0); cycle();
        instr(8, 5, 1, 1, 1, 0, 0, 1, 0, 0);
        #1 chk("lu_hazard_on", 32'(bus.hazard_stall), 32'd1);
        cycle();
        chk("lu_bubble_valid", 32'(bus.ex_valid), 32'd0);
        bus.mem_valid = 1; bus.mem_reg_write = 1; bus.mem_rd = 5;
        #1 chk("lu_hazard_off", 32'(bus.hazard_stall), 32'd0);
        cycle();
        chk("lu_a_sel", 32'(bus.ex_a_sel), 32'd2);
        chk("lu_valid", 32'(bus.ex_valid), 32'd1);
        bus.mem_valid = 0;

        // store data with immediate: EX writes x5, ID sw x5,8(x2)
        instr(5, 1, 2, 1, 1, 0, 0, 1, 0, 0); cycle();
        instr(0, 2, 5, 1, 1, 0, 1, 0, 0, 1); cycle();
        chk("st_b_sel", 32'(bus.ex_b_sel), 32'd3);
        chk("st_st_sel", 32'(bus.ex_st_sel), 32'd1);
        chk("st_a_sel", 32'(bus.ex_a_sel), 32'd0);

        // x0 never forwarded
        instr(0, 1, 2, 1, 1, 0, 0, 1, 0, 0); cycle();
        instr(7, 0, 3, 1, 1, 0, 0, 1, 0, 0); cycle();
        chk("x0_a_sel", 32'(bus.ex_a_sel), 32'd0);

        // flush together with stall kills the incoming store
        instr(0, 2, 5, 1, 1, 0, 1, 0, 0, 1);
        bus.flush = 1; bus.stall = 1; cycle();
        chk("flush_valid", 32'(bus.ex_valid), 32'd0);
        chk("flush_mem_write", 32'(bus.ex_mem_write), 32'd0);

        // stall alone holds everything for three cycles
        instr(4, 1, 2, 1, 1, 1, 1, 1, 1, 0); cycle();
        snap[0] = bus.ex_pc; snap[1] = bus.ex_imm;
        snap[2] = {26'd0, bus.ex_a_sel, bus.ex_b_sel, bus.ex_valid, bus.ex_mem_read};
        snap[3] = 32'(bus.ex_rd);
        for (int i = 0; i < 3; i++) begin
            rand_in();
            bus.stall = 1; bus.flush = 0;
            cycle();
            chk("stall_pc", bus.ex_pc, snap[0]);
            chk("stall_imm", bus.ex_imm, snap[1]);
            chk("stall_ctl", {26'd0, bus.ex_a_sel, bus.ex_b_sel, bus.ex_valid, bus.ex_mem_read}, snap[2]);
            chk("stall_rd", 32'(bus.ex_rd), snap[3]);
        end

        for (int i = 0; i < 400; i++) begin
            rand_in();
            cycle();
        end

        // asynchronous reset mid-cycle with a valid instruction in EX
        instr(3, 1, 2, 1, 1, 0, 0, 1, 1, 1); cycle();
        chk("pre_reset_valid", 32'(bus.ex_valid), 32'd1);
        #2 rst_n = 0;
        #1;
        model_reset();
        check_all();
        chk("areset_pc", bus.ex_pc, 32'd0);
        chk("areset_rd", 32'(bus.ex_rd), 32'd0);
        chk("areset_hazard", 32'(bus.hazard_stall), 32'd0);
        #1 rst_n = 1;
        instr(6, 3, 0, 1, 0, 1, 1, 1, 0, 0); cycle();
        chk("post_reset_valid", 32'(bus.ex_valid), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
